arbitro_uart_trigger: RTL and testbench



---
 rtl/arbitro_uart_trigger_pkg.sv | 20 ++
 rtl/arbitro_uart_trigger_if.sv | 18 +
 rtl/arbitro_uart_trigger_tx_core.sv | 116 +++++++++++
 rtl/arbitro_uart_trigger.sv | 68 ++++++
 tb/tb_arbitro_uart_trigger.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_uart_trigger_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the request-to-UART arbiter:
//   tx_state_t            - transmitter FSM state encoding
//   CLKS_PER_BIT_DEFAULT  - clk cycles per UART bit (50 MHz / 9600 baud)
//   CMD_BYTE_DEFAULT      - command byte sent for each request
// ---------------------------------------------------------------------------
package arbitro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int         CLKS_PER_BIT_DEFAULT = 5208;
  localparam logic [7:0] CMD_BYTE_DEFAULT     = 8'h01;

endpackage

// File: rtl/arbitro_uart_trigger_if.sv
// ---------------------------------------------------------------------------
// arbitro_uart_trigger_if
// Groups the request line and the serial output of the arbiter.
//   in - request line, asynchronous to clk, level-sampled
//   tx - UART serial output, idle high
// Modports:
//   master - the board side: drives in, observes tx
//   slave  - the arbiter: samples in, drives tx
// ---------------------------------------------------------------------------
interface arbitro_uart_trigger_if;

  logic in;
  logic tx;

  modport master (output in, input tx);
  modport slave  (input in, output tx);

endinterface

// File: rtl/arbitro_uart_trigger_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// 8N1 UART transmitter: start bit 0, data LSB first, stop bit 1, each bit
// held for CLKS_PER_BIT clk cycles. tx comes straight from a flop.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low; aborts any frame, tx goes high
//   start - accepted only in IDLE; the start bit begins on that edge
//   data  - byte to send, captured when start is accepted
//   tx    - serial output, idle high
//   busy  - high while a frame (START/DATA/STOP) is in progress
// ---------------------------------------------------------------------------
module uart_tx_core
  import arbitro_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          bitEnd;

  assign bitEnd = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the value of the bit that begins on the next edge, so every
  // state transition also loads the level of the bit it enters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          data_d  = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = data_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bitEnd) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          state_d = IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/arbitro_uart_trigger.sv
// ---------------------------------------------------------------------------
// arbitro_uart_trigger
// Each rising edge on the request line sends CMD_BYTE once as an 8N1 frame.
// A request arriving while a frame is in flight is held in a one-deep
// pending latch and sent right after the current frame.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - slave modport: bus.in request line, bus.tx serial output
// ---------------------------------------------------------------------------
module arbitro_uart_trigger
  import arbitro_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] CMD_BYTE     = CMD_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  arbitro_uart_trigger_if.slave  bus
);

  // s2Dly_q is the previous s2 sample used by the edge detector.
  logic s1_q, s2_q, s2Dly_q;
  logic pending_q, pending_d;
  logic rise;
  logic start;
  logic busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s2Dly_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      s1_q      <= bus.in;
      s2_q      <= s1_q;
      s2Dly_q   <= s2_q;
      pending_q <= pending_d;
    end
  end

  assign rise  = s2_q & ~s2Dly_q;
  assign start = (rise | pending_q) & ~busy;

  // A start consumes the pending request; a rise that coincides with a
  // start from pending is dropped, as is any rise while already pending.
  always_comb begin
    pending_d = pending_q;
    if (start) begin
      pending_d = 1'b0;
    end else if (rise) begin
      pending_d = 1'b1;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .data (CMD_BYTE),
    .tx   (bus.tx),
    .busy (busy)
  );

endmodule

// File: tb/tb_arbitro_uart_trigger.sv
// ---------------------------------------------------------------------------
// tb_arbitro_uart_trigger
// Two arbiters (CMD_BYTE 01 and A5, CLKS_PER_BIT=4) share clk and reset.
// A frame-level reference model per lane predicts when each frame starts
// and what its 40 tx samples are; a monitor per lane pops and compares.
// ---------------------------------------------------------------------------
module tb_arbitro_uart_trigger;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    int               startCyc;
    logic [FRAME-1:0] pattern;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  logic inDrv [2];
  logic txMon [2];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   framesExp [2];
  int   framesSeen [2];

  always #10 clk = ~clk;

  // Edge counter: after posedge k (and until the next one) cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] cmdOf(int lane);
    return (lane == 0) ? 8'h01 : 8'hA5;
  endfunction

  // Frame as seen on tx, one entry per clk cycle: start 0, data LSB first, stop 1.
  function automatic logic [FRAME-1:0] framePattern(logic [7:0] b);
    logic [9:0]       bits;
    logic [FRAME-1:0] p;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) p[i] = bits[i / CPB];
    return p;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic waitCycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // One request pulse on a lane, width in clk cycles.
  task automatic applyStimulus(int lane, int width);
    @(negedge clk);
    inDrv[lane] = 1'b1;
    repeat (width) @(negedge clk);
    inDrv[lane] = 1'b0;
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    arbitro_uart_trigger_if ifc ();

    assign ifc.in   = inDrv[g];
    assign txMon[g] = ifc.tx;

    arbitro_uart_trigger #(
      .CLKS_PER_BIT(CPB),
      .CMD_BYTE    ((g == 0) ? 8'h01 : 8'hA5)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (ifc)
    );

    frame_t           expq [$];
    frame_t           nf, cf;
    logic             h0, h1, h2, pending, rise, busy;
    int               lastStart, e, nSamp;
    logic             capturing = 1'b0;
    logic [FRAME-1:0] got, want;

    // Reference model: a request is a low-to-high change of the sampled
    // input, acted on two edges after it is first sampled high. The line
    // is busy for FRAME edges after a start; one request may wait.
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        pending   = 1'b0;
        lastStart = -1000;
        expq.delete();
      end else begin
        e    = cyc + 1;
        rise = h1 & ~h2;
        busy = (e <= lastStart + FRAME);
        if (!busy && (rise || pending)) begin
          nf.startCyc = e;
          nf.pattern  = framePattern(cmdOf(g));
          expq.push_back(nf);
          lastStart = e;
          pending   = 1'b0;
          framesExp[g]++;
        end else if (rise) begin
          pending = 1'b1;
        end
        h2 = h1; h1 = h0; h0 = inDrv[g];
      end
    end

    // Monitor: a low tx while idle opens a frame; 40 samples close it.
    always @(negedge clk) begin
      if (!reset) begin
        capturing = 1'b0;
      end else if (!capturing) begin
        if (txMon[g] !== 1'b1) begin
          if (expq.size() == 0) begin
            checks++;
            $display("[TB] FAIL lane%0d unexpected frame: tx low at cycle %0d, required idle 1", g, cyc);
            want = framePattern(cmdOf(g));
          end else begin
            cf = expq.pop_front();
            checkOutput($sformatf("lane%0d frame start cycle", g), 64'(cyc), 64'(cf.startCyc));
            want = cf.pattern;
            framesSeen[g]++;
          end
          capturing = 1'b1;
          got       = '0;
          got[0]    = txMon[g];
          nSamp     = 1;
        end else if (expq.size() != 0 && expq[0].startCyc < cyc) begin
          checks++;
          $display("[TB] FAIL lane%0d missing frame: no start bit, required at cycle %0d", g, expq[0].startCyc);
          void'(expq.pop_front());
        end
      end else begin
        got[nSamp] = txMon[g];
        nSamp++;
        if (nSamp == FRAME) begin
          checkOutput($sformatf("lane%0d frame bits", g), 64'(got), 64'(want));
          capturing = 1'b0;
        end
      end
    end
  end

  initial begin
    int before0, before1;
    framesExp[0] = 0; framesExp[1] = 0;
    framesSeen[0] = 0; framesSeen[1] = 0;
    inDrv[0] = 1'b0;
    inDrv[1] = 1'b0;
    reset    = 1'b1;
    #1 reset = 1'b0;

    // Requests toggling under reset must produce nothing.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      inDrv[0] = i[0];
      inDrv[1] = ~i[0];
    end
    #1;
    checkOutput("lane0 tx under reset", 64'(txMon[0]), 64'd1);
    checkOutput("lane1 tx under reset", 64'(txMon[1]), 64'd1);

    // Request already high at release: exactly one frame, none while held.
    @(negedge clk);
    inDrv[0] = 1'b1;
    inDrv[1] = 1'b0;
    #2 reset = 1'b1;
    waitCycles(120);
    checkOutput("lane0 frames for held request", 64'(framesSeen[0]), 64'd1);
    inDrv[0] = 1'b0;
    waitCycles(10);

    // Single 3-cycle pulse on the A5 lane.
    before1 = framesSeen[1];
    applyStimulus(1, 3);
    waitCycles(60);
    checkOutput("lane1 frames for single pulse", 64'(framesSeen[1] - before1), 64'd1);

    // Second pulse lands during DATA: two back-to-back frames.
    before0 = framesSeen[0];
    applyStimulus(0, 2);
    waitCycles(15);
    applyStimulus(0, 2);
    waitCycles(100);
    checkOutput("lane0 frames for two pulses", 64'(framesSeen[0] - before0), 64'd2);

    // Three pulses inside one frame: pending holds only one.
    before1 = framesSeen[1];
    applyStimulus(1, 2);
    waitCycles(5);
    applyStimulus(1, 2);
    waitCycles(5);
    applyStimulus(1, 2);
    waitCycles(100);
    checkOutput("lane1 frames for three pulses", 64'(framesSeen[1] - before1), 64'd2);

    // Random request activity on both lanes.
    repeat (800) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        if ($urandom_range(0, 11) == 0) inDrv[g] = ~inDrv[g];
    end
    inDrv[0] = 1'b0;
    inDrv[1] = 1'b0;
    waitCycles(120);

    // Reset in the middle of data bit 3 of an A5 frame.
    applyStimulus(1, 2);
    waitCycles(18);
    checkOutput("lane1 tx during data bit 3", 64'(txMon[1]), 64'd0);
    #3 reset = 1'b0;
    #1;
    checkOutput("lane1 tx right after async reset", 64'(txMon[1]), 64'd1);
    checkOutput("lane0 tx right after async reset", 64'(txMon[0]), 64'd1);
    waitCycles(3);
    before0 = framesSeen[0];
    before1 = framesSeen[1];
    #2 reset = 1'b1;
    waitCycles(80);
    checkOutput("lane0 frames after reset with in low", 64'(framesSeen[0] - before0), 64'd0);
    checkOutput("lane1 frames after reset with in low", 64'(framesSeen[1] - before1), 64'd0);
    checkOutput("lane1 tx idle after reset", 64'(txMon[1]), 64'd1);

    checkOutput("lane0 frames seen vs predicted", 64'(framesSeen[0]), 64'(framesExp[0]));
    checkOutput("lane1 frames seen vs predicted", 64'(framesSeen[1]), 64'(framesExp[1]));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
